// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding and stream framing sizes.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } ldr_state_t;

    localparam int LOADER_DEFAULT_DEPTH = 4096;
    localparam int WORD_BYTES           = 4;

endpackage

// File: rtl/inst_mem_loader_le_word_assembler.sv
// Packs accepted bytes into a little-endian 32-bit word.
// word/word_done are valid in the cycle the 4th byte is accepted.
module le_word_assembler
    import inst_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_cnt;
    logic [31:0] r_sh;

    // Shift each byte in from the top so the first byte ends at [7:0].
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= 2'd0;
            r_sh  <= 32'd0;
        end else if (i_accept) begin
            r_cnt <= r_cnt + 2'd1;
            r_sh  <= {i_byte, r_sh[31:8]};
        end
    end

    assign o_word      = {i_byte, r_sh[31:8]};
    assign o_word_done = i_accept && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream instruction memory loader: length header, LE words,
// single-cycle writes, core held in reset while loading.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DEPTH     = LOADER_DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    ldr_state_t r_state;
    ldr_state_t w_state_nxt;

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last;

    logic        w_accept;
    logic        w_start;
    logic        w_word_done;
    logic [31:0] w_word;
    logic        w_len_done;
    logic        w_data_done;

    assign byte_ready_o = (r_state == S_LEN) || (r_state == S_DATA);
    assign core_hold_o  = (r_state == S_LEN) || (r_state == S_DATA)
                       || (r_state == S_ERR);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERR);

    assign w_accept = byte_valid_i && byte_ready_o;
    assign w_start  = start_i && ((r_state == S_IDLE)
                    || (r_state == S_DONE) || (r_state == S_ERR));

    assign w_len_done  = (r_state == S_LEN) && w_word_done;
    assign w_data_done = (r_state == S_DATA) && w_word_done;

    le_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start),
        .i_accept    (w_accept),
        .i_byte      (byte_i),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_word_done) begin
                    if (w_word == 32'd0) begin
                        w_state_nxt = S_DONE;
                    end else if (w_word > 32'(DEPTH)) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_done && (r_idx == r_last)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word index and last-index capture from the length header.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_last <= '0;
        end else if (w_start) begin
            r_idx  <= '0;
            r_last <= '0;
        end else if (w_len_done) begin
            r_last <= IDX_W'(w_word - 32'd1);
        end else if (w_data_done) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Registered memory write port; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= 32'd0;
        end else begin
            we_o <= 1'b0;
            if (w_data_done) begin
                we_o    <= 1'b1;
                waddr_o <= BASE_ADDR + ADDR_W'({r_idx, 2'b00});
                wdata_o <= w_word;
            end
        end
    end

endmodule
